// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID->EX issue stage for the 4-bit-control ALU.
// Decodes a 16-bit instruction into alu_cntrl, selects operand B (register or
// immediate) and holds the result in a valid/ready main register backed by a
// one-entry skid buffer, so id_ready can be a registered signal.
// Optional feature macro: ALU_ISSUE_PERF_EN adds saturating perf_issued and
// perf_illegal counters (ports absent when undefined).
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and ex_* stay stable while
// ex_valid && !ex_ready.
module alu_issue_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [15:0]       id_instr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] ex_alu_a,
    output logic [DATA_W-1:0] ex_alu_b,
    output logic [3:0]        ex_alu_cntrl,
    output logic              ex_illegal,
    output logic [1:0]        dbg_state
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_issued,
    output logic [CNT_W-1:0]  perf_illegal
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   id_ready_q;

    logic [DATA_W-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;
    logic [3:0]        main_c_q, skid_c_q;
    logic              main_ill_q, skid_ill_q;

    logic [DATA_W-1:0] dec_a, dec_b;
    logic [3:0]        dec_c;
    logic              dec_ill;
    logic [5:0]        imm6;
    logic [DATA_W-1:0] imm_sext, imm_zext;

    logic in_xfer, out_xfer;
    logic load_main_dec, load_skid, main_from_skid;

    assign in_xfer  = id_valid && id_ready_q;
    assign out_xfer = (state_q != EMPTY) && ex_ready;

    assign imm6     = id_instr[5:0];
    assign imm_sext = {{(DATA_W-6){imm6[5]}}, imm6};
    assign imm_zext = {{(DATA_W-6){1'b0}}, imm6};

    // Instruction decode: operand B selection and ALU control; undecodable
    // ops still issue as an ADD of rs/rt with the illegal flag set.
    always_comb begin
        dec_a   = id_rs_data;
        dec_b   = id_rt_data;
        dec_c   = 4'b0010;
        dec_ill = 1'b0;
        case (id_instr[15:12])
            4'b0000: begin
                case (id_instr[2:0])
                    3'b000:  dec_c = 4'b0000;
                    3'b001:  dec_c = 4'b0001;
                    3'b010:  dec_c = 4'b0010;
                    3'b110:  dec_c = 4'b0110;
                    3'b111:  dec_c = 4'b0111;
                    default: dec_ill = 1'b1;
                endcase
            end
            4'b0001, 4'b0010, 4'b0011: begin
                dec_c = 4'b0010;
                dec_b = imm_sext;
            end
            4'b0100: dec_c = 4'b0110;
            4'b0101: begin
                dec_c = 4'b0111;
                dec_b = imm_sext;
            end
            4'b0110: begin
                dec_c = 4'b0000;
                dec_b = imm_zext;
            end
            4'b0111: begin
                dec_c = 4'b0001;
                dec_b = imm_zext;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    // Occupancy FSM: next state and datapath load controls; flush overrides all.
    always_comb begin
        state_d        = state_q;
        load_main_dec  = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d       = ONE;
                    load_main_dec = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_d   = TWO;
                    load_skid = 1'b1;
                end else if (out_xfer && !in_xfer) begin
                    state_d = EMPTY;
                end else if (in_xfer && out_xfer) begin
                    load_main_dec = 1'b1;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d        = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d        = EMPTY;
            load_main_dec  = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // State register and registered id_ready (tracks the next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            id_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            id_ready_q <= (state_d != TWO);
        end
    end

    // Main and skid payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_a_q   <= '0;
            main_b_q   <= '0;
            main_c_q   <= 4'b0010;
            main_ill_q <= 1'b0;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
            skid_c_q   <= 4'b0010;
            skid_ill_q <= 1'b0;
        end else begin
            if (load_main_dec) begin
                main_a_q   <= dec_a;
                main_b_q   <= dec_b;
                main_c_q   <= dec_c;
                main_ill_q <= dec_ill;
            end else if (main_from_skid) begin
                main_a_q   <= skid_a_q;
                main_b_q   <= skid_b_q;
                main_c_q   <= skid_c_q;
                main_ill_q <= skid_ill_q;
            end
            if (load_skid) begin
                skid_a_q   <= dec_a;
                skid_b_q   <= dec_b;
                skid_c_q   <= dec_c;
                skid_ill_q <= dec_ill;
            end
        end
    end

    assign id_ready     = id_ready_q;
    assign ex_valid     = (state_q != EMPTY);
    assign ex_alu_a     = main_a_q;
    assign ex_alu_b     = main_b_q;
    assign ex_alu_cntrl = main_c_q;
    assign ex_illegal   = main_ill_q;
    assign dbg_state    = state_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [CNT_W-1:0] issued_q, illegal_q;

    // Saturating counters of output transfers; flush does not clear them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q  <= '0;
            illegal_q <= '0;
        end else if (out_xfer) begin
            if (!(&issued_q))
                issued_q <= issued_q + 1'b1;
            if (main_ill_q && !(&illegal_q))
                illegal_q <= illegal_q + 1'b1;
        end
    end

    assign perf_issued  = issued_q;
    assign perf_illegal = illegal_q;
`endif

endmodule
